// File: rtl/traffic_sensor_conditioner.sv
// Purpose: conditions five raw vehicle detectors into latched per-lane requests for the
//          traffic light controller, with debounce, serve-based clearing and starvation flags.
// Latency: raw high from sampling edge N -> req after edge N+1+DEB_CYCLES with TSC_SYNC_EN,
//          N+DEB_CYCLES-1 without; green -> request clear takes one edge.
// Backpressure: none; requests stay latched until the controller shows green on that lane.
//
// Optional build macro: TSC_SYNC_EN (2-flop input synchronizer; undefined = sample raw_sensor directly).
//
// Ports:
//   clk         clock
//   reset       synchronous, active-high reset
//   raw_sensor  [4:0] raw detectors {e_left, w_left, e_str, w_str, ns}
//   light       [9:0] controller lights, 2 bits per lane, same lane order; 2'b10 = green
//   req         [4:0] conditioned requests
//   starve      [4:0] lane has waited MAX_WAIT cycles unserved
//   any_req     OR of req
module traffic_sensor_conditioner #(
    parameter int DEB_CYCLES = 3,
    parameter int MAX_WAIT   = 31
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] raw_sensor,
    input  logic [9:0] light,
    output logic [4:0] req,
    output logic [4:0] starve,
    output logic       any_req
);

    localparam int DW = $clog2(DEB_CYCLES + 1);
    localparam int WW = $clog2(MAX_WAIT + 1);
    // deb_cnt value held in ARM just before the final accepted sample
    localparam logic [DW-1:0] DEB_LAST = DW'(DEB_CYCLES - 1);
    localparam logic [WW-1:0] WAIT_MAX = WW'(MAX_WAIT);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARM   = 2'd1,
        PEND  = 2'd2,
        SERVE = 2'd3
    } lane_state_t;

    lane_state_t   state_q [5];
    lane_state_t   state_d [5];
    logic [DW-1:0] deb_q   [5];
    logic [DW-1:0] deb_d   [5];
    logic [WW-1:0] wait_q  [5];
    logic [WW-1:0] wait_d  [5];

    logic [4:0] s;
    logic [4:0] green;

`ifdef TSC_SYNC_EN
    logic [4:0] sync1_q;
    logic [4:0] sync2_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= raw_sensor;
            sync2_q <= sync1_q;
        end
    end

    assign s = sync2_q;
`else
    // Without the synchronizer the SERVE-state request follows the raw input directly.
    assign s = raw_sensor;
`endif

    // Only 2'b10 is green; yellow, red and the unused 2'b11 code all count as not green.
    always_comb begin
        green = '0;
        for (int i = 0; i < 5; i++) begin
            green[i] = (light[2*i +: 2] == 2'b10);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 5; i++) begin
                state_q[i] <= IDLE;
                deb_q[i]   <= '0;
                wait_q[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < 5; i++) begin
                state_q[i] <= state_d[i];
                deb_q[i]   <= deb_d[i];
                wait_q[i]  <= wait_d[i];
            end
        end
    end

    always_comb begin
        for (int i = 0; i < 5; i++) begin
            state_d[i] = state_q[i];
            deb_d[i]   = deb_q[i];
            wait_d[i]  = wait_q[i];
            req[i]     = 1'b0;
            starve[i]  = 1'b0;

            case (state_q[i])
                IDLE: begin
                    deb_d[i]  = '0;
                    wait_d[i] = '0;
                    if (s[i]) begin
                        if (DEB_CYCLES == 1) begin
                            // Single-sample debounce completes immediately; green serves it at once.
                            state_d[i] = green[i] ? SERVE : PEND;
                        end else begin
                            state_d[i] = ARM;
                            deb_d[i]   = DW'(1);
                        end
                    end
                end

                ARM: begin
                    if (s[i]) begin
                        if (deb_q[i] == DEB_LAST) begin
                            state_d[i] = green[i] ? SERVE : PEND;
                            deb_d[i]   = '0;
                        end else begin
                            deb_d[i] = deb_q[i] + 1'b1;
                        end
                    end else begin
                        state_d[i] = IDLE;
                        deb_d[i]   = '0;
                    end
                end

                PEND: begin
                    req[i]    = 1'b1;
                    starve[i] = (wait_q[i] == WAIT_MAX);
                    if (green[i]) begin
                        // Serving takes priority over a saturated wait counter.
                        state_d[i] = SERVE;
                        wait_d[i]  = '0;
                    end else if (wait_q[i] != WAIT_MAX) begin
                        wait_d[i] = wait_q[i] + 1'b1;
                    end
                end

                SERVE: begin
                    // A vehicle still present keeps the request up through the green.
                    req[i] = s[i];
                    if (!green[i]) begin
                        wait_d[i]  = '0;
                        state_d[i] = s[i] ? PEND : IDLE;
                    end
                end

                default: begin
                    state_d[i] = IDLE;
                end
            endcase
        end
    end

    assign any_req = |req;

endmodule
